matrix_dump: RTL and testbench

Reads a contiguous range of matrices out of data memory after the CPU has finished executing and streams them out one 16-bit element at a time over a valid/ready handshake. It is the read-back side of the matrix pipeline: the execution engine writes 4x4 results into data memory, and this block drains them for checking or off-chip transfer. It sits beside `data_mem` on a dedicated read port and is started by the top level once the program counter has finished its program.

---
 rtl/matrix_dump.sv | 121 ++++++++++++
 tb/tb_matrix_dump.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_dump.sv
// Drains a contiguous range of 4x4 matrices from data memory and streams them
// out one element at a time over a valid/ready handshake.
module matrix_dump #(
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [16*ELEM_W-1:0]  mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ELEM_W-1:0]     out_data,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [3:0]            out_index,
  output logic                  out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_W-1:0]     r_addrCnt;
  logic [ADDR_W-1:0]     r_remain;
  logic [16*ELEM_W-1:0]  r_hold;
  logic [3:0]            r_elemCnt;

  logic                  w_accept;
  logic                  w_lastElem;
  logic [3:0]            w_elemSel;

  assign w_accept   = (r_state == S_SEND) && out_ready;
  assign w_lastElem = (r_elemCnt == 4'd15);
  // Element 0 sits in the MSBs, so slot e is counted from the top of the word.
  assign w_elemSel  = 4'd15 - r_elemCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nextState = (count != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: w_nextState = S_WAIT;
      S_WAIT: w_nextState = S_SEND;
      S_SEND: begin
        if (w_accept && w_lastElem) begin
          w_nextState = (r_remain == ADDR_W'(1)) ? S_DONE : S_READ;
        end
      end
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Address/remaining counters advance only when a matrix's final element is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addrCnt <= '0;
      r_remain  <= '0;
      r_hold    <= '0;
      r_elemCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (count != '0)) begin
            r_addrCnt <= first_addr;
            r_remain  <= count;
          end
        end
        S_WAIT: begin
          r_hold    <= mem_rdata;
          r_elemCnt <= '0;
        end
        S_SEND: begin
          if (w_accept) begin
            r_elemCnt <= r_elemCnt + 4'd1;
            if (w_lastElem) begin
              r_remain  <= r_remain - ADDR_W'(1);
              r_addrCnt <= r_addrCnt + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign mem_rd    = (r_state == S_READ);
  assign mem_addr  = mem_rd ? r_addrCnt : '0;
  assign out_valid = (r_state == S_SEND);
  assign out_data  = r_hold[w_elemSel*ELEM_W +: ELEM_W];
  assign out_addr  = r_addrCnt;
  assign out_index = r_elemCnt;
  assign out_last  = (r_state == S_SEND) && (r_remain == ADDR_W'(1)) && w_lastElem;

endmodule

// File: tb/tb_matrix_dump.sv
// Directed self-checking bench for matrix_dump with a registered-read memory model.
module tb_matrix_dump;

  logic         clk;
  logic         reset;
  logic         start;
  logic [6:0]   first_addr;
  logic [6:0]   count;
  logic         busy;
  logic         done;
  logic         mem_rd;
  logic [6:0]   mem_addr;
  logic [255:0] mem_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [6:0]   out_addr;
  logic [3:0]   out_index;
  logic         out_last;

  int total;
  int bad;

  logic [255:0] mem [128];

  matrix_dump #(.ELEM_W(16), .ADDR_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_index  (out_index),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data appears exactly one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [15:0] elemVal(input int a, input int e);
    if (a == 5) return 16'(e);
    return {7'(a), 5'b0, 4'(e)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, done, mem_rd, out_valid, out_last} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b want=00000", {busy, done, mem_rd, out_valid, out_last});
    end
    total++;
    if ({mem_addr, out_data, out_addr, out_index} !== 34'h0) begin
      bad++;
      $display("[TB] FAIL reset_values got=%h want=0", {mem_addr, out_data, out_addr, out_index});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    first_addr = 7'd5; count = 7'd1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 7'd5 || out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_read rd=%b addr=%0d valid=%b busy=%b want 1/5/0/1", mem_rd, mem_addr, out_valid, busy);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || mem_rd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_wait valid=%b rd=%b want 0/0", out_valid, mem_rd);
    end
    tick();
    for (int e = 0; e < 16; e++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== elemVal(5, e) || out_addr !== 7'd5 ||
          out_index !== 4'(e) || out_last !== (e == 15)) begin
        bad++;
        $display("[TB] FAIL single_elem%0d got v=%b d=%h a=%0d i=%0d l=%b want v=1 d=%h a=5 i=%0d l=%b",
                 e, out_valid, out_data, out_addr, out_index, out_last, elemVal(5, e), e, (e == 15));
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_done done=%b valid=%b busy=%b want 1/0/1", done, out_valid, busy);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_idle done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int rdCnt = 0;
    bit doneSeen = 0;
    bit prevStall = 0;
    logic [29:0] snap = '0;
    logic [6:0] expAddr;
    first_addr = 7'd10; count = 7'd3; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 1500 && !doneSeen; cyc++) begin
      if (mem_rd) rdCnt++;
      if (prevStall) begin
        total++;
        if ({out_valid, out_data, out_addr, out_index, out_last} !== snap) begin
          bad++;
          $display("[TB] FAIL bp_stable got=%h want=%h", {out_valid, out_data, out_addr, out_index, out_last}, snap);
        end
      end
      if (done) begin
        doneSeen = 1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          expAddr = 7'(10 + idx / 16);
          total++;
          if (out_data !== elemVal(int'(expAddr), idx % 16) || out_addr !== expAddr ||
              out_index !== 4'(idx % 16) || out_last !== (idx == 47)) begin
            bad++;
            $display("[TB] FAIL bp_elem%0d got d=%h a=%0d i=%0d l=%b want d=%h a=%0d i=%0d l=%b",
                     idx, out_data, out_addr, out_index, out_last,
                     elemVal(int'(expAddr), idx % 16), expAddr, idx % 16, (idx == 47));
          end
          idx++;
        end
        prevStall = out_valid && !out_ready;
        snap = {out_valid, out_data, out_addr, out_index, out_last};
        tick();
      end
    end
    out_ready = 1'b1;
    total++;
    if (!doneSeen || idx != 48 || rdCnt != 3) begin
      bad++;
      $display("[TB] FAIL bp_summary done=%0d elems=%0d reads=%0d want 1/48/3", doneSeen, idx, rdCnt);
    end
    tick();
  endtask

  task automatic test_wrap();
    int idx = 0;
    int rdCnt = 0;
    bit doneSeen = 0;
    logic [6:0] expRd [3] = '{7'd126, 7'd127, 7'd0};
    logic [6:0] expAddr;
    first_addr = 7'd126; count = 7'd3; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !doneSeen; cyc++) begin
      if (mem_rd) begin
        total++;
        if (rdCnt > 2 || mem_addr !== expRd[rdCnt > 2 ? 2 : rdCnt]) begin
          bad++;
          $display("[TB] FAIL wrap_rd%0d got=%0d want=%0d", rdCnt, mem_addr, expRd[rdCnt > 2 ? 2 : rdCnt]);
        end
        rdCnt++;
      end
      if (out_valid) begin
        expAddr = 7'((126 + idx / 16) % 128);
        total++;
        if (out_addr !== expAddr || out_data !== elemVal(int'(expAddr), idx % 16)) begin
          bad++;
          $display("[TB] FAIL wrap_elem%0d got a=%0d d=%h want a=%0d d=%h", idx, out_addr, out_data,
                   expAddr, elemVal(int'(expAddr), idx % 16));
        end
        idx++;
      end
      if (done) doneSeen = 1;
      tick();
    end
    total++;
    if (!doneSeen || idx != 48 || rdCnt != 3) begin
      bad++;
      $display("[TB] FAIL wrap_summary done=%0d elems=%0d reads=%0d want 1/48/3", doneSeen, idx, rdCnt);
    end
  endtask

  task automatic test_zero_count();
    int stray = 0;
    first_addr = 7'd9; count = 7'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || mem_rd !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_done done=%b busy=%b rd=%b valid=%b want 1/1/0/0", done, busy, mem_rd, out_valid);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_idle done=%b busy=%b want 0/0", done, busy);
    end
    for (int i = 0; i < 6; i++) begin
      if (mem_rd || out_valid || done) stray++;
      tick();
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("[TB] FAIL zero_quiet got=%0d want=0 stray cycles", stray);
    end
  endtask

  task automatic test_start_while_busy();
    int idx = 0;
    int rdCnt = 0;
    bit doneSeen = 0;
    bit pulsed = 0;
    logic [6:0] expAddr;
    first_addr = 7'd20; count = 7'd2; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !doneSeen; cyc++) begin
      start = 1'b0;
      if (mem_rd) begin
        total++;
        if (mem_addr !== 7'(20 + rdCnt)) begin
          bad++;
          $display("[TB] FAIL busy_rd%0d got=%0d want=%0d", rdCnt, mem_addr, 20 + rdCnt);
        end
        rdCnt++;
      end
      if (out_valid) begin
        expAddr = 7'(20 + idx / 16);
        total++;
        if (out_addr !== expAddr || out_data !== elemVal(int'(expAddr), idx % 16) || out_index !== 4'(idx % 16)) begin
          bad++;
          $display("[TB] FAIL busy_elem%0d got a=%0d d=%h i=%0d want a=%0d d=%h i=%0d", idx, out_addr,
                   out_data, out_index, expAddr, elemVal(int'(expAddr), idx % 16), idx % 16);
        end
        if (idx == 4 && !pulsed) begin
          start = 1'b1; first_addr = 7'd40; count = 7'd5; pulsed = 1;
        end
        idx++;
      end
      if (done) doneSeen = 1;
      tick();
    end
    start = 1'b0;
    total++;
    if (!doneSeen || idx != 32 || rdCnt != 2) begin
      bad++;
      $display("[TB] FAIL busy_summary done=%0d elems=%0d reads=%0d want 1/32/2", doneSeen, idx, rdCnt);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_after busy=%b rd=%b want 0/0", busy, mem_rd);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit hit = 0;
    int got = 0;
    first_addr = 7'd5; count = 7'd2; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      if (out_valid && out_index == 4'd7) hit = 1;
      else tick();
    end
    total++;
    if (!hit) begin
      bad++;
      $display("[TB] FAIL rst_reach got=0 want=1 (element 7 never presented)");
    end
    reset = 1'b1;
    tick();
    total++;
    if ({busy, done, mem_rd, out_valid, out_last} !== 5'b0 ||
        {mem_addr, out_data, out_addr, out_index} !== 34'h0) begin
      bad++;
      $display("[TB] FAIL rst_values got flags=%b vals=%h want 0/0", {busy, done, mem_rd, out_valid, out_last},
               {mem_addr, out_data, out_addr, out_index});
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (done !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rst_quiet%0d done=%b rd=%b busy=%b want 0/0/0", i, done, mem_rd, busy);
      end
      tick();
    end
    first_addr = 7'd5; count = 7'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      if (out_valid) begin
        total++;
        if (out_data !== elemVal(5, got) || out_index !== 4'(got) || out_addr !== 7'd5) begin
          bad++;
          $display("[TB] FAIL rst_fresh%0d got d=%h i=%0d a=%0d want d=%h i=%0d a=5", got, out_data,
                   out_index, out_addr, elemVal(5, got), got);
        end
        got++;
      end
      tick();
    end
    total++;
    if (got != 16 || done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_fresh_done elems=%0d done=%b want 16/1", got, done);
    end
    tick();
  endtask

  initial begin
    logic [255:0] tmp;
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    first_addr = '0;
    count = '0;
    out_ready = 1'b0;
    mem_rdata = '0;
    for (int a = 0; a < 128; a++) begin
      tmp = '0;
      for (int e = 0; e < 16; e++) tmp[255 - 16*e -: 16] = elemVal(a, e);
      mem[a] = tmp;
    end
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
